// File: rtl/paddle_pkg.sv
// paddle_pkg: shared FSM encoding and default constants for the paddle tracker
package paddle_pkg;

    localparam int POT_W        = 8;
    localparam int POS_W        = 10;
    localparam int DEF_DEADZONE = 41;
    localparam int DEF_MAX_POS  = 430;
    localparam int DEF_AVG_LOG2 = 2;
    localparam int DEF_MAX_STEP = 8;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        FILTER = 4'b0010,
        SCALE  = 4'b0100,
        SLEW   = 4'b1000
    } state_t;

endpackage

// File: rtl/paddle_tracker_moving_avg.sv
// moving_avg: running-sum moving average over 2^LOG2 samples
//   clk, reset (async, active-high), load (commit sample), sample,
//   avg (sum >> LOG2), done (one-cycle pulse the cycle after a load)
module moving_avg
    import paddle_pkg::*;
#(
    parameter int W    = POT_W,
    parameter int LOG2 = DEF_AVG_LOG2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] sample,
    output logic [W-1:0] avg,
    output logic         done
);

    localparam int N  = 1 << LOG2;
    localparam int SW = W + LOG2;

    logic [W-1:0]    r_buf [N];
    logic [LOG2-1:0] r_wp;
    logic [SW-1:0]   r_sum;
    logic            r_primed;
    logic            r_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) r_buf[i] <= '0;
            r_wp     <= '0;
            r_sum    <= '0;
            r_primed <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= load;
            if (load) begin
                if (!r_primed) begin
                    // first sample fills the window so the average starts settled
                    for (int i = 0; i < N; i++) r_buf[i] <= sample;
                    r_sum    <= SW'(sample) << LOG2;
                    r_primed <= 1'b1;
                end else begin
                    r_sum       <= r_sum - SW'(r_buf[r_wp]) + SW'(sample);
                    r_buf[r_wp] <= sample;
                    r_wp        <= r_wp + 1'b1;
                end
            end
        end
    end

    assign avg  = W'(r_sum >> LOG2);
    assign done = r_done;

endmodule

// File: rtl/paddle_tracker.sv
// paddle_tracker: conditions a raw pot reading into a clamped paddle Y position
//   clk, reset (async, active-high), tick (update strobe), pot_value (raw 8-bit),
//   pos_y (10-bit position), pos_valid (update pulse), busy, moving
//   Build option PADDLE_TRACKER_SLEW_EN limits each update to MAX_STEP pixels.
module paddle_tracker
    import paddle_pkg::*;
#(
    parameter int DEADZONE = DEF_DEADZONE,
    parameter int MAX_POS  = DEF_MAX_POS,
`ifdef PADDLE_TRACKER_SLEW_EN
    parameter int MAX_STEP = DEF_MAX_STEP,
`endif
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [POT_W-1:0] pot_value,
    output logic [POS_W-1:0] pos_y,
    output logic             pos_valid,
    output logic             busy,
    output logic             moving
);

    state_t           r_state, w_next;
    logic             w_load;
    logic [POT_W-1:0] r_sample;
    logic [POT_W-1:0] w_avg;
    logic             w_done;
    logic [POS_W-1:0] w_scaled;
    logic [POS_W-1:0] w_off;
    logic [POS_W-1:0] w_target;
    logic [POS_W-1:0] r_target;
    logic [POS_W-1:0] w_new;
    logic [POS_W-1:0] r_pos_y;
    logic             r_pos_valid;
    logic             r_moving;

    moving_avg #(.W(POT_W), .LOG2(AVG_LOG2)) u_avg (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .sample (r_sample),
        .avg    (w_avg),
        .done   (w_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        case (r_state)
            IDLE:    w_next = tick ? FILTER : IDLE;
            FILTER:  begin
                w_load = 1'b1;
                w_next = SCALE;
            end
            SCALE:   w_next = SLEW;
            SLEW:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // avg*2 spans 0..510, stretching the pot range over the screen
    assign w_scaled = POS_W'({w_avg, 1'b0});
    assign w_off    = w_scaled - POS_W'(DEADZONE);
    assign w_target = (w_scaled < POS_W'(DEADZONE)) ? '0 :
                      (w_off > POS_W'(MAX_POS))     ? POS_W'(MAX_POS) : w_off;

`ifdef PADDLE_TRACKER_SLEW_EN
    logic             w_up;
    logic [POS_W-1:0] w_diff;
    always_comb begin
        w_up   = r_target > r_pos_y;
        w_diff = w_up ? r_target - r_pos_y : r_pos_y - r_target;
        w_new  = (w_diff <= POS_W'(MAX_STEP)) ? r_target :
                 w_up ? r_pos_y + POS_W'(MAX_STEP) : r_pos_y - POS_W'(MAX_STEP);
    end
`else
    assign w_new = r_target;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample    <= '0;
            r_target    <= '0;
            r_pos_y     <= '0;
            r_pos_valid <= 1'b0;
            r_moving    <= 1'b0;
        end else begin
            r_pos_valid <= 1'b0;
            if (r_state == IDLE && tick) r_sample <= pot_value;
            if (r_state == SCALE && w_done) r_target <= w_target;
            if (r_state == SLEW) begin
                r_pos_y     <= w_new;
                r_pos_valid <= 1'b1;
                r_moving    <= w_new != r_pos_y;
            end
        end
    end

    assign busy      = r_state != IDLE;
    assign pos_y     = r_pos_y;
    assign pos_valid = r_pos_valid;
    assign moving    = r_moving;

endmodule

// File: tb/tb_paddle_tracker.sv
// tb_paddle_tracker: directed self-checking bench for paddle_tracker
module tb_paddle_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [7:0] pot_value = '0;
    logic [9:0] pos_y;
    logic       pos_valid;
    logic       busy;
    logic       moving;
    int         total = 0;
    int         bad = 0;

    paddle_tracker dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .pot_value (pot_value),
        .pos_y     (pos_y),
        .pos_valid (pos_valid),
        .busy      (busy),
        .moving    (moving)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // extra >= 0 raises a second tick at the negedge after edge 'extra' of the update
    task automatic step(input string tag, input logic [7:0] v, input int exp_y,
                        input int exp_mv, input int extra);
        int n;
        int nb;
        int np;
        @(negedge clk);
        pot_value = v;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        n = 0;
        nb = 0;
        while (pos_valid !== 1'b1 && n < 10) begin
            if (busy === 1'b1) nb++;
            if (n == extra) tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            n++;
        end
        chk({tag, "_lat"}, n, 3);
        chk({tag, "_busycyc"}, nb, 3);
        chk({tag, "_pos"}, int'(pos_y), exp_y);
        chk({tag, "_mv"}, int'(moving), exp_mv);
        np = 0;
        repeat (8) begin
            @(negedge clk);
            if (pos_valid === 1'b1) np++;
        end
        chk({tag, "_extra_pulses"}, np, 0);
    endtask

    initial begin
        int np;
        do_reset();
        chk("rst_pos", int'(pos_y), 0);
        chk("rst_valid", int'(pos_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_moving", int'(moving), 0);

        step("zero", 8'd0, 0, 0, -1);

        do_reset();
`ifdef PADDLE_TRACKER_SLEW_EN
        for (int k = 1; k <= 27; k++)
            step("ramp", 8'd128, (8 * k < 215) ? 8 * k : 215, 1, -1);
        step("ramp_hold", 8'd128, 215, 0, -1);
`else
        step("mid128", 8'd128, 215, 1, -1);

        do_reset();
        step("clamp255", 8'd255, 430, 1, -1);
        do_reset();
        step("dz20", 8'd20, 0, 0, -1);
        do_reset();
        step("dz21", 8'd21, 1, 1, -1);

        do_reset();
        step("prime0", 8'd0, 0, 0, -1);
        step("avg1", 8'd255, 85, 1, -1);
        step("avg2", 8'd255, 213, 1, -1);
        step("avg3", 8'd255, 341, 1, -1);
        step("avg4", 8'd255, 430, 1, -1);
        step("avg5", 8'd255, 430, 0, -1);

        do_reset();
        step("prime0b", 8'd0, 0, 0, -1);
        step("busytick", 8'd255, 85, 1, 0);
        step("after_busy", 8'd255, 213, 1, -1);
        step("slewtick", 8'd255, 341, 1, 2);

        @(negedge clk);
        pot_value = 8'd50;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_pos", int'(pos_y), 0);
        chk("abort_valid", int'(pos_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_moving", int'(moving), 0);
        reset = 1'b0;
        np = 0;
        repeat (6) begin
            @(negedge clk);
            if (pos_valid === 1'b1) np++;
        end
        chk("abort_no_pulse", np, 0);
        step("reprime100", 8'd100, 159, 1, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
